countdown_60: RTL and testbench

Loadable two-digit BCD down-counter: the counting-down counterpart of the digital clock's mod-60 up-counter, used for timer and countdown modes. It counts a preset value down to 00 with one decrement per enabled `CP` edge. It then either wraps to 59 and emits a borrow pulse for cascading into a minutes stage, or stops and flags expiry. It feeds the same 8-bit BCD display path as the up-counter.

---
 rtl/countdown_60_pkg.sv | 33 +++
 rtl/countdown_60_if.sv | 28 ++
 rtl/countdown_60_bcd_digit_dec.sv | 29 ++
 rtl/countdown_60.sv | 149 ++++++++++++++
 tb/tb_countdown_60.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/countdown_60_pkg.sv
// Shared clock package: state encoding, BCD digit width and BCD helpers.
// Imported by the countdown counter, its interface and its digit decrementer.
package countdown_60_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_BYTE_W  = 2 * BCD_DIGIT_W;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_RUN     = 2'd1;
    localparam logic [1:0] STATE_EXPIRED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE,
        ST_RUN     = STATE_RUN,
        ST_EXPIRED = STATE_EXPIRED
    } cd_state_e;

    // Both nibbles of a two-digit BCD byte are decimal digits.
    function automatic logic bcd_is_valid(input logic [BCD_BYTE_W-1:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Binary value of a two-digit BCD byte (nibbles taken at face value).
    function automatic int unsigned bcd_to_bin(input logic [BCD_BYTE_W-1:0] v);
        return 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
    endfunction

    // Two-digit BCD encoding of a binary value in 0..99.
    function automatic logic [BCD_BYTE_W-1:0] bin_to_bcd(input int unsigned v);
        return {4'(v / 32'd10), 4'(v % 32'd10)};
    endfunction

endpackage

// File: rtl/countdown_60_if.sv
// Control/status bundle of the countdown counter.
//   master: drives EN, Load, Din, Start, Halt; observes Cnt, Bo, Done, Busy, LdErr
//   slave : the counter side
interface countdown_60_if;
    import countdown_60_pkg::*;

    logic                  EN;
    logic                  Load;
    logic [BCD_BYTE_W-1:0] Din;
    logic                  Start;
    logic                  Halt;
    logic [BCD_BYTE_W-1:0] Cnt;
    logic                  Bo;
    logic                  Done;
    logic                  Busy;
    logic                  LdErr;

    modport master (
        output EN, Load, Din, Start, Halt,
        input  Cnt, Bo, Done, Busy, LdErr
    );

    modport slave (
        input  EN, Load, Din, Start, Halt,
        output Cnt, Bo, Done, Busy, LdErr
    );

endinterface

// File: rtl/countdown_60_bcd_digit_dec.sv
// Single BCD digit decrementer with borrow chaining (combinational).
//   digit_i  : current digit
//   borrow_i : decrement request from the lower digit (1 for the ones digit)
//   digit_c  : next digit value
//   borrow_c : this digit wrapped 0 -> 9 and borrows from the next digit
module bcd_digit_dec
    import countdown_60_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    input  logic                   borrow_i,
    output logic [BCD_DIGIT_W-1:0] digit_c,
    output logic                   borrow_c
);

    always_comb begin
        digit_c  = digit_i;
        borrow_c = 1'b0;
        if (borrow_i) begin
            if (digit_i == '0) begin
                digit_c  = BCD_DIGIT_W'(9);
                borrow_c = 1'b1;
            end else begin
                // Non-decimal digits (A..F) also step down, so they drain to 0.
                digit_c = digit_i - BCD_DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_60.sv
// Loadable two-digit BCD down-counter for timer/countdown modes.
// Counts a preset down to 00, then wraps to MODULUS-1 with a one-cycle borrow
// (WRAP=1) or stops and flags expiry (WRAP=0).
//
// Parameters: MODULUS (2..100, count range 00..MODULUS-1), WRAP.
// Ports:
//   CP    : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : countdown_60_if.slave
//           in : EN, Load, Din[7:0] (BCD), Start, Halt
//           out: Cnt[7:0] (BCD), Bo, Done, Busy, LdErr (all registered)
// Build option: COUNTDOWN_LOADCHK_EN replaces out-of-range/non-BCD loads with
// MODULUS-1 and pulses LdErr; without it Din loads verbatim and LdErr stays 0.
module countdown_60
    import countdown_60_pkg::*;
#(
    parameter int unsigned MODULUS = 60,
    parameter bit          WRAP    = 1'b1
) (
    input  logic           CP,
    input  logic           reset,
    countdown_60_if.slave  bus
);

    localparam logic [BCD_BYTE_W-1:0] RELOAD = bin_to_bcd(MODULUS - 32'd1);

    cd_state_e             state_q, state_d;
    logic [BCD_BYTE_W-1:0] cnt_q,   cnt_d;
    logic                  bo_q,    bo_d;
    logic                  done_q,  done_d;
    logic                  busy_q,  busy_d;
    logic                  lderr_q, lderr_d;

    logic [BCD_DIGIT_W-1:0] ones_dec_c, tens_dec_c;
    logic                   ones_borrow_c;
    logic                   at_zero_c;
    logic [BCD_BYTE_W-1:0]  dec_c;

    // Ones digit always decrements; tens decrements only when ones borrows.
    bcd_digit_dec u_ones (
        .digit_i  (cnt_q[3:0]),
        .borrow_i (1'b1),
        .digit_c  (ones_dec_c),
        .borrow_c (ones_borrow_c)
    );

    // Tens borrow-out is set exactly when the count is 00.
    bcd_digit_dec u_tens (
        .digit_i  (cnt_q[7:4]),
        .borrow_i (ones_borrow_c),
        .digit_c  (tens_dec_c),
        .borrow_c (at_zero_c)
    );

    assign dec_c = {tens_dec_c, ones_dec_c};

    // State and output registers.
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= RELOAD;
            bo_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bo_q    <= bo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            lderr_q <= lderr_d;
        end
    end

    // Next state and next register values; priority Load > Halt > Start > count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bo_d    = 1'b0;
        done_d  = done_q;
        lderr_d = 1'b0;

        if (bus.Load) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
`ifdef COUNTDOWN_LOADCHK_EN
            if (!bcd_is_valid(bus.Din) || (bcd_to_bin(bus.Din) >= MODULUS)) begin
                cnt_d   = RELOAD;
                lderr_d = 1'b1;
            end else begin
                cnt_d = bus.Din;
            end
`else
            cnt_d = bus.Din;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.Halt && bus.Start) begin
                        if (!WRAP && at_zero_c) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.Halt) begin
                        state_d = ST_IDLE;
                    end else if (bus.EN) begin
                        if (at_zero_c) begin
                            // Only reachable at 00 with WRAP=1 in normal use.
                            if (WRAP) begin
                                cnt_d = RELOAD;
                                bo_d  = 1'b1;
                            end else begin
                                state_d = ST_EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = dec_c;
                            if (!WRAP && (dec_c == '0)) begin
                                state_d = ST_EXPIRED;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_EXPIRED: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    assign bus.Cnt   = cnt_q;
    assign bus.Bo    = bo_q;
    assign bus.Done  = done_q;
    assign bus.Busy  = busy_q;
    assign bus.LdErr = lderr_q;

endmodule

// File: tb/tb_countdown_60.sv
// Directed bench for countdown_60: one wrapping and one expiring instance,
// both driven by the same stimulus.
module tb_countdown_60;

    logic CP    = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    countdown_60_if w_if ();
    countdown_60_if s_if ();

    countdown_60 #(.MODULUS(60), .WRAP(1'b1)) dut_wrap (
        .CP    (CP),
        .reset (reset),
        .bus   (w_if.slave)
    );

    countdown_60 #(.MODULUS(60), .WRAP(1'b0)) dut_stop (
        .CP    (CP),
        .reset (reset),
        .bus   (s_if.slave)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic load, input logic [7:0] din,
                         input logic start, input logic halt);
        w_if.EN = en;  w_if.Load = load; w_if.Din = din; w_if.Start = start; w_if.Halt = halt;
        s_if.EN = en;  s_if.Load = load; s_if.Din = din; s_if.Start = start; s_if.Halt = halt;
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    // Load a value and leave controls idle.
    task automatic load_val(input logic [7:0] v);
        drive(1'b0, 1'b1, v, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        check("rst_cnt",  32'(w_if.Cnt),  32'h59);
        check("rst_busy", 32'(w_if.Busy), 32'h0);
        check("rst_bo",   32'(w_if.Bo),   32'h0);
        check("rst_done", 32'(s_if.Done), 32'h0);
        check("rst_lderr",32'(w_if.LdErr),32'h0);
        reset = 1'b0;

        // WRAP=1: 02,01,00,59,58 with Bo only on 59.
        load_val(8'h02);
        check("w_load_cnt", 32'(w_if.Cnt), 32'h02);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("w_start_busy", 32'(w_if.Busy), 32'h1);
        check("w_start_cnt",  32'(w_if.Cnt),  32'h02);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(); check("w_c01", 32'(w_if.Cnt), 32'h01); check("w_bo01", 32'(w_if.Bo), 32'h0);
        step(); check("w_c00", 32'(w_if.Cnt), 32'h00); check("w_bo00", 32'(w_if.Bo), 32'h0);
        step(); check("w_c59", 32'(w_if.Cnt), 32'h59); check("w_bo59", 32'(w_if.Bo), 32'h1);
        check("w_busy59", 32'(w_if.Busy), 32'h1);
        step(); check("w_c58", 32'(w_if.Cnt), 32'h58); check("w_bo58", 32'(w_if.Bo), 32'h0);
        check("w_done", 32'(w_if.Done), 32'h0);

        // EN gating and Halt+Start.
        load_val(8'h20);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step(); check("g_en1", 32'(w_if.Cnt), 32'h19);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step(); check("g_en0", 32'(w_if.Cnt), 32'h19);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step(); check("g_en1b", 32'(w_if.Cnt), 32'h18);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1); step();
        check("hs_cnt",  32'(w_if.Cnt),  32'h18);
        check("hs_busy", 32'(w_if.Busy), 32'h0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
        check("idle_en_ignored", 32'(w_if.Cnt), 32'h18);

        // Tens borrow, then Load during RUN.
        load_val(8'h40);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
        check("tens_borrow", 32'(w_if.Cnt), 32'h39);
        drive(1'b1, 1'b1, 8'h25, 1'b0, 1'b0); step();
        check("run_load_cnt",  32'(w_if.Cnt),  32'h25);
        check("run_load_busy", 32'(w_if.Busy), 32'h0);

        // WRAP=0: 03,02,01,00 then expired.
        load_val(8'h03);
        check("s_load", 32'(s_if.Cnt), 32'h03);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        check("s_busy", 32'(s_if.Busy), 32'h1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(); check("s_c02", 32'(s_if.Cnt), 32'h02);
        step(); check("s_c01", 32'(s_if.Cnt), 32'h01); check("s_done01", 32'(s_if.Done), 32'h0);
        step(); check("s_c00", 32'(s_if.Cnt), 32'h00); check("s_done00", 32'(s_if.Done), 32'h1);
        check("s_exp_busy", 32'(s_if.Busy), 32'h0);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0); step(); step();
        check("s_exp_hold", 32'(s_if.Cnt), 32'h00);
        check("s_exp_done", 32'(s_if.Done), 32'h1);
        check("s_exp_busy2", 32'(s_if.Busy), 32'h0);
        load_val(8'h10);
        check("s_reload_cnt",  32'(s_if.Cnt),  32'h10);
        check("s_reload_done", 32'(s_if.Done), 32'h0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
        check("s_idle_after_load", 32'(s_if.Cnt), 32'h10);

        // Start at 00: expiring instance expires at once, wrapping one runs.
        load_val(8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        check("s_start00_done", 32'(s_if.Done), 32'h1);
        check("s_start00_busy", 32'(s_if.Busy), 32'h0);
        check("w_start00_busy", 32'(w_if.Busy), 32'h1);

        // Asynchronous reset mid-count at 37.
        load_val(8'h37);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_cnt",  32'(w_if.Cnt),  32'h37);
        check("pre_rst_busy", 32'(w_if.Busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_cnt",  32'(w_if.Cnt),  32'h59);
        check("async_rst_busy", 32'(w_if.Busy), 32'h0);
        check("async_rst_bo",   32'(w_if.Bo),   32'h0);
        check("async_rst_done", 32'(s_if.Done), 32'h0);
        #2;
        reset = 1'b0;

        // Load range checking.
        load_val(8'h6A);
`ifdef COUNTDOWN_LOADCHK_EN
        check("bad_load_cnt",   32'(w_if.Cnt),   32'h59);
        check("bad_load_lderr", 32'(w_if.LdErr), 32'h1);
        step();
        check("lderr_pulse", 32'(w_if.LdErr), 32'h0);
`else
        check("raw_load_cnt",   32'(w_if.Cnt),   32'h6A);
        check("raw_load_lderr", 32'(w_if.LdErr), 32'h0);
`endif
        load_val(8'h45);
        check("good_load_cnt",   32'(w_if.Cnt),   32'h45);
        check("good_load_lderr", 32'(w_if.LdErr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
